// File: rtl/lc_prefetch_unit_if.sv
// Memory fetch port between the prefetch unit (master) and the memory (slave).
// The master holds fetch_req/fetch_addr until the slave returns fetch_ack with fetch_data.
interface lc_prefetch_unit_if #(parameter int LC_W = 26);
  logic            fetch_req;
  logic [LC_W-3:0] fetch_addr;
  logic            fetch_ack;
  logic [31:0]     fetch_data;

  modport master (output fetch_req, fetch_addr, input fetch_ack, fetch_data);
  modport slave  (input fetch_req, fetch_addr, output fetch_ack, fetch_data);
endinterface

// File: rtl/lc_prefetch_unit.sv
// Location counter with a sequential 32-bit word prefetch queue.
// The LC steps by byte or halfword; the head queue entry supplies the current
// halfword/byte, and a one-outstanding fetch FSM keeps the queue topped up.
module lc_prefetch_unit #(
  parameter int LC_W  = 26,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             lc_load,
  input  logic [LC_W-1:0]  lc_load_val,
  input  logic             lc_inc,
  input  logic             byte_mode,
  lc_prefetch_unit_if.master mem,
  output logic [LC_W-1:0]  lc,
  output logic             inst_valid,
  output logic [15:0]      inst,
  output logic             needfetch
);
  localparam int WA_W  = LC_W - 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  typedef struct packed {
    logic [WA_W-1:0] tag;
    logic [31:0]     data;
  } entry_t;

  state_t                 state_q, state_d;
  logic [LC_W-1:0]        lc_q, lc_d, lc_step;
  logic [CNT_W-1:0]       count_q, count_d, wr_idx;
  entry_t [DEPTH-1:0]     q_q, q_d;
  logic [WA_W-1:0]        addr_q, addr_d, last_tag_q, last_tag_d;
  logic                   do_load, do_inc, pop, push;
  entry_t                 head;
  logic [15:0]            half_v;
  logic [7:0]             byte_v;

  // LC next value plus the pop/push decisions that depend on it
  always_comb begin
    do_load = step & lc_load;
    do_inc  = step & lc_inc & ~lc_load;
    lc_step = lc_q + (byte_mode ? LC_W'(1) : LC_W'(2));
    lc_d    = lc_q;
    if (do_load)     lc_d = lc_load_val;
    else if (do_inc) lc_d = lc_step;
    // Only an increment that leaves the current word retires the head
    pop  = do_inc && (count_q != '0) && (lc_step[LC_W-1:2] != lc_q[LC_W-1:2]);
    // A load in the same cycle as an ack discards the returning word
    push = (state_q == REQ) && mem.fetch_ack && !do_load;
  end

  // Queue next state: shift on pop, write behind the surviving entries on push
  always_comb begin
    q_d        = q_q;
    count_d    = count_q;
    last_tag_d = last_tag_q;
    wr_idx     = count_q - CNT_W'(pop);
    if (do_load) begin
      count_d = '0;
    end else begin
      if (pop)
        for (int i = 0; i < DEPTH - 1; i++) q_d[i] = q_q[i+1];
      if (push) begin
        for (int i = 0; i < DEPTH; i++)
          if (CNT_W'(i) == wr_idx) begin
            q_d[i].tag  = addr_q;
            q_d[i].data = mem.fetch_data;
          end
        last_tag_d = addr_q;
      end
      count_d = count_q - CNT_W'(pop) + CNT_W'(push);
    end
  end

  // Fetch FSM: issue when there is room, hold until ack, swallow data after a flush
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (count_d < CNT_W'(DEPTH)) begin
        state_d = REQ;
        addr_d  = (count_d == '0) ? lc_d[LC_W-1:2] : last_tag_d + WA_W'(1);
      end
      REQ: begin
        if (mem.fetch_ack)  state_d = IDLE;
        else if (do_load)   state_d = DROP;
      end
      DROP: if (mem.fetch_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lc_q       <= '0;
      count_q    <= '0;
      q_q        <= '0;
      addr_q     <= '0;
      last_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      lc_q       <= lc_d;
      count_q    <= count_d;
      q_q        <= q_d;
      addr_q     <= addr_d;
      last_tag_q <= last_tag_d;
    end
  end

  // Instruction select from the head word at the registered LC
  always_comb begin
    head       = q_q[0];
    inst_valid = (count_q != '0) && (head.tag == lc_q[LC_W-1:2]);
    half_v     = lc_q[1] ? head.data[31:16] : head.data[15:0];
    case (lc_q[1:0])
      2'd0:    byte_v = head.data[7:0];
      2'd1:    byte_v = head.data[15:8];
      2'd2:    byte_v = head.data[23:16];
      default: byte_v = head.data[31:24];
    endcase
    inst = '0;
    if (inst_valid) inst = byte_mode ? {8'h00, byte_v} : half_v;
  end

  assign needfetch      = ~inst_valid;
  assign lc             = lc_q;
  assign mem.fetch_req  = (state_q != IDLE);
  assign mem.fetch_addr = addr_q;
endmodule

// File: tb/tb_lc_prefetch_unit.sv
// Directed bench for lc_prefetch_unit: stimulus pushes expected fetch addresses
// and expected {lc, inst} presentations; a monitor pops and compares them.
module tb_lc_prefetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step = 1'b0, lc_load = 1'b0, lc_inc = 1'b0, byte_mode = 1'b0;
  logic [25:0] lc_load_val = '0;
  logic [25:0] lc;
  logic        inst_valid, needfetch;
  logic [15:0] inst;

  lc_prefetch_unit_if #(.LC_W(26)) mem_if ();

  lc_prefetch_unit #(.LC_W(26), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .step(step), .lc_load(lc_load),
    .lc_load_val(lc_load_val), .lc_inc(lc_inc), .byte_mode(byte_mode),
    .mem(mem_if), .lc(lc), .inst_valid(inst_valid), .inst(inst),
    .needfetch(needfetch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] lc;
    logic [15:0] inst;
  } inst_exp_t;

  inst_exp_t   exp_inst_q[$];
  logic [23:0] exp_req_q[$];
  int          total = 0;
  int          bad = 0;
  logic        prev_req = 1'b0, prev_vld = 1'b0;
  logic [25:0] prev_lc = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  task automatic exp_i(input logic [25:0] l, input logic [15:0] i);
    inst_exp_t e;
    e.lc = l; e.inst = i;
    exp_inst_q.push_back(e);
  endtask

  task automatic exp_r(input logic [23:0] a);
    exp_req_q.push_back(a);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_inc();
    step = 1'b1; lc_inc = 1'b1;
    @(negedge clk);
    step = 1'b0; lc_inc = 1'b0;
  endtask

  task automatic do_load(input logic [25:0] v);
    step = 1'b1; lc_load = 1'b1; lc_load_val = v;
    @(negedge clk);
    step = 1'b0; lc_load = 1'b0;
  endtask

  task automatic do_ack(input logic [31:0] d);
    int k = 0;
    while (!mem_if.fetch_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_wait", {31'b0, mem_if.fetch_req}, 32'd1);
    mem_if.fetch_ack = 1'b1; mem_if.fetch_data = d;
    @(negedge clk);
    mem_if.fetch_ack = 1'b0;
  endtask

  initial begin
    mem_if.fetch_ack  = 1'b0;
    mem_if.fetch_data = '0;
    fork
      // Monitor: new request edges and new instruction presentations
      forever begin
        @(negedge clk);
        if (mem_if.fetch_req && !prev_req) begin
          if (exp_req_q.size() == 0) begin
            total++; bad++;
            $display("FAIL req_unexpected: got addr %0h want none", mem_if.fetch_addr);
          end else chk("req_addr", {8'b0, mem_if.fetch_addr}, {8'b0, exp_req_q.pop_front()});
        end
        if (inst_valid && (!prev_vld || lc != prev_lc)) begin
          if (exp_inst_q.size() == 0) begin
            total++; bad++;
            $display("FAIL inst_unexpected: got lc %0h inst %0h want none", lc, inst);
          end else begin
            inst_exp_t e;
            e = exp_inst_q.pop_front();
            chk("inst_lc", {6'b0, lc}, {6'b0, e.lc});
            chk("inst", {16'b0, inst}, {16'b0, e.inst});
          end
        end
        prev_req = mem_if.fetch_req;
        prev_vld = inst_valid;
        prev_lc  = lc;
      end
      // Stimulus
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_lc", {6'b0, lc}, 32'd0);
        chk("rst_needfetch", {31'b0, needfetch}, 32'd1);
        chk("rst_req", {31'b0, mem_if.fetch_req}, 32'd0);
        chk("rst_inst", {16'b0, inst}, 32'd0);
        exp_r(24'h0);

        // Fill the queue from lc=0
        exp_i(26'h0, 16'h2222); exp_r(24'h1);
        do_ack(32'h1111_2222);
        chk("req_gap", {31'b0, mem_if.fetch_req}, 32'd0);
        do_ack(32'h3333_4444);
        cyc(2);
        chk("full_noreq", {31'b0, mem_if.fetch_req}, 32'd0);
        mem_if.fetch_ack = 1'b1; mem_if.fetch_data = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_if.fetch_ack = 1'b0;
        cyc(1);
        chk("ack_idle_req", {31'b0, mem_if.fetch_req}, 32'd0);
        chk("ack_idle_inst", {16'b0, inst}, 32'h2222);
        lc_inc = 1'b1;
        @(negedge clk);
        lc_inc = 1'b0;
        chk("nostep_lc", {6'b0, lc}, 32'd0);

        // In-word inc, cross-word pop, then ack coinciding with a pop
        exp_i(26'h2, 16'h1111); do_inc();
        exp_i(26'h4, 16'h4444); exp_r(24'h2); do_inc();
        exp_i(26'h6, 16'h3333); do_inc();
        exp_i(26'h8, 16'h6666); exp_r(24'h3);
        step = 1'b1; lc_inc = 1'b1; mem_if.fetch_ack = 1'b1; mem_if.fetch_data = 32'h5555_6666;
        @(negedge clk);
        step = 1'b0; lc_inc = 1'b0; mem_if.fetch_ack = 1'b0;
        chk("pushpop_valid", {31'b0, inst_valid}, 32'd1);
        do_ack(32'h7777_8888);

        // Load 0x100, halfword select
        exp_r(24'h40);
        do_load(26'h100);
        chk("load_req", {31'b0, mem_if.fetch_req}, 32'd1);
        chk("load_addr", {8'b0, mem_if.fetch_addr}, 32'h40);
        chk("load_needfetch", {31'b0, needfetch}, 32'd1);
        exp_i(26'h100, 16'h1234); exp_r(24'h41);
        do_ack(32'hBEEF_1234);
        exp_i(26'h102, 16'hBEEF); do_inc();

        // Load while the request for 0x41 is outstanding
        exp_r(24'h80);
        do_load(26'h200);
        chk("drop_req", {31'b0, mem_if.fetch_req}, 32'd1);
        chk("drop_addr", {8'b0, mem_if.fetch_addr}, 32'h41);
        cyc(1);
        chk("drop_hold", {8'b0, mem_if.fetch_addr}, 32'h41);
        do_ack(32'hDEAD_DEAD);
        chk("drop_discard", {31'b0, inst_valid}, 32'd0);
        chk("drop_gap", {31'b0, mem_if.fetch_req}, 32'd0);

        // Byte mode across a word boundary
        exp_i(26'h200, 16'hF00D); exp_r(24'h81);
        do_ack(32'h0BAD_F00D);
        do_ack(32'h1234_5678);
        byte_mode = 1'b1;
        exp_r(24'h40);
        do_load(26'h103);
        exp_i(26'h103, 16'h00AA); exp_r(24'h41);
        do_ack(32'hAABB_CCDD);
        do_ack(32'h1122_3344);
        exp_i(26'h104, 16'h0044); exp_r(24'h42); do_inc();
        exp_i(26'h105, 16'h0033); do_inc();

        // Top-of-space wrap
        byte_mode = 1'b0;
        exp_r(24'hFF_FFFF);
        do_load(26'h3FF_FFFC);
        do_ack(32'h0);
        exp_i(26'h3FF_FFFC, 16'hF00D); exp_r(24'h0);
        do_ack(32'hCAFE_F00D);
        do_ack(32'h9ABC_5678);
        exp_i(26'h3FF_FFFE, 16'hCAFE); do_inc();
        exp_i(26'h0, 16'h5678); exp_r(24'h1); do_inc();
        cyc(3);
        chk("wrap_lc", {6'b0, lc}, 32'd0);
        chk("req_left", exp_req_q.size(), 32'd0);
        chk("inst_left", exp_inst_q.size(), 32'd0);
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
